// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: run/pause/clear sequencer for the prescaled 0-999 counter.
// Commands are single-cycle, level-sampled pulses resolved by priority
// reset > clear > pause > start; every output comes straight from a register.
module counter_run_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int MAX      = 999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       wrap_en,
  input  logic [9:0] limit,
  output logic [9:0] count,
  output logic [1:0] state,
  output logic       running,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0] MAX_V = 10'(MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  state_t        state_q, state_n;
  logic [9:0]    count_q, count_n;
  logic [9:0]    lim_q, lim_n;
  logic [PW-1:0] pre_q, pre_n;
  logic          done_q, done_n;
  logic          tick;
  logic          go;
  logic [9:0]    lim_clamped;

  // A pause in the same cycle outranks start, so start only acts alone.
  assign go          = start & ~pause;
  assign tick        = (pre_q == TICK_LAST);
  assign lim_clamped = (limit > MAX_V) ? MAX_V : limit;

  // State, counter, prescaler, latched limit and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      pre_q   <= '0;
      lim_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      pre_q   <= pre_n;
      lim_q   <= lim_n;
      done_q  <= done_n;
    end
  end

  // Next-state logic: clear aborts from anywhere, otherwise per-state commands and ticks.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    pre_n   = pre_q;
    lim_n   = lim_q;
    done_n  = 1'b0;
    if (clear) begin
      state_n = IDLE;
      count_n = '0;
      pre_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            lim_n   = lim_clamped;
            pre_n   = '0;
            state_n = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (tick) begin
            pre_n = '0;
            if (count_q != lim_q) begin
              count_n = count_q + 10'd1;
            end else if (wrap_en) begin
              count_n = '0;
              done_n  = 1'b1;
            end else begin
              state_n = DONE_ST;
              done_n  = 1'b1;
            end
          end else begin
            pre_n = pre_q + PW'(1);
          end
        end
        PAUSED: begin
          if (go) begin
            state_n = RUN;
          end
        end
        DONE_ST: begin
          if (go) begin
            count_n = '0;
            pre_n   = '0;
            lim_n   = lim_clamped;
            state_n = RUN;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign count   = count_q;
  assign state   = state_q;
  assign running = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl: scenario tasks for counter_run_ctrl. Each task queues the
// expected outputs for chosen cycles after its start edge, then walks the clock
// and pops/compares entries as their cycle comes up.
module tb_counter_run_ctrl;

  typedef struct {
    int         cyc;
    logic [9:0] cnt;
    logic [1:0] st;
    logic       dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, pause, clear, wrap_en;
  logic [9:0] limit;
  logic [9:0] count;
  logic [1:0] state;
  logic       running, done;

  logic       start1, clear1;
  logic [9:0] limit1;
  logic [9:0] count1;
  logic [1:0] state1;
  logic       running1, done1;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  counter_run_ctrl #(.TICK_DIV(4), .MAX(999)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .wrap_en(wrap_en), .limit(limit), .count(count), .state(state),
    .running(running), .done(done)
  );

  counter_run_ctrl #(.TICK_DIV(1), .MAX(999)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pause(1'b0), .clear(clear1),
    .wrap_en(1'b0), .limit(limit1), .count(count1), .state(state1),
    .running(running1), .done(done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int cyc, input int cnt, input int st, input logic dn);
    exp_t x;
    x.cyc = cyc;
    x.cnt = 10'(cnt);
    x.st  = 2'(st);
    x.dn  = dn;
    sb.push_back(x);
  endtask

  task automatic go_idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Start pulse sampled at the next edge, which becomes E0.
  task automatic fire_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({count, state, done, running} !== {10'd0, 2'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset count=%0d state=%0d done=%b running=%b expected 0/0/0/0",
               count, state, done, running);
    end
    total++;
    if ({count1, state1, done1, running1} !== {10'd0, 2'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_div1 count=%0d state=%0d done=%b running=%b expected 0/0/0/0",
               count1, state1, done1, running1);
    end
  endtask

  task automatic test_stop_at_limit();
    limit = 10'd5; wrap_en = 1'b0;
    for (int n = 0; n <= 27; n++)
      push(n, (n / 4 > 5) ? 5 : n / 4, (n >= 24) ? 3 : 1, n == 24);
    fire_start();
    for (int n = 0; n <= 27; n++) begin
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if ({count, state, done, running} !== {e.cnt, e.st, e.dn, e.st == 2'd1}) begin
          bad++;
          $display("FAIL stop n=%0d got count=%0d state=%0d done=%b running=%b want count=%0d state=%0d done=%b",
                   n, count, state, done, running, e.cnt, e.st, e.dn);
        end
      end
      step();
    end
  endtask

  task automatic test_restart_from_done();
    limit = 10'd2;
    for (int n = 0; n <= 14; n++)
      push(n, (n / 4 > 2) ? 2 : n / 4, (n >= 12) ? 3 : 1, n == 12);
    fire_start();
    for (int n = 0; n <= 14; n++) begin
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if ({count, state, done, running} !== {e.cnt, e.st, e.dn, e.st == 2'd1}) begin
          bad++;
          $display("FAIL restart n=%0d got count=%0d state=%0d done=%b want count=%0d state=%0d done=%b",
                   n, count, state, done, e.cnt, e.st, e.dn);
        end
      end
      step();
    end
  endtask

  task automatic test_wrap();
    go_idle();
    limit = 10'd5; wrap_en = 1'b1;
    for (int n = 0; n <= 50; n++)
      push(n, (n % 24) / 4, 1, (n > 0) && (n % 24 == 0));
    fire_start();
    for (int n = 0; n <= 50; n++) begin
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if ({count, state, done, running} !== {e.cnt, e.st, e.dn, e.st == 2'd1}) begin
          bad++;
          $display("FAIL wrap n=%0d got count=%0d state=%0d done=%b want count=%0d state=%0d done=%b",
                   n, count, state, done, e.cnt, e.st, e.dn);
        end
      end
      step();
    end
    wrap_en = 1'b0;
  endtask

  // Pause lands while the prescaler holds 2 with count=1; resume at E17.
  task automatic test_pause_resume();
    go_idle();
    limit = 10'd5;
    for (int n = 0; n <= 6; n++) push(n, n / 4, 1, 1'b0);
    for (int n = 7; n <= 16; n++) push(n, 1, 2, 1'b0);
    for (int n = 17; n <= 23; n++) push(n, (n < 19) ? 1 : ((n < 23) ? 2 : 3), 1, 1'b0);
    fire_start();
    for (int n = 0; n <= 23; n++) begin
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if ({count, state, done, running} !== {e.cnt, e.st, e.dn, e.st == 2'd1}) begin
          bad++;
          $display("FAIL pause n=%0d got count=%0d state=%0d done=%b want count=%0d state=%0d done=%b",
                   n, count, state, done, e.cnt, e.st, e.dn);
        end
      end
      pause = (n == 6);
      start = (n == 16);
      step();
    end
    pause = 1'b0; start = 1'b0;
  endtask

  // Clear+start at count=3, then pause+start on an edge that would also tick.
  task automatic test_clear_priority();
    go_idle();
    limit = 10'd5;
    for (int n = 0; n <= 12; n++) push(n, n / 4, 1, 1'b0);
    for (int n = 13; n <= 16; n++) push(n, 0, 0, 1'b0);
    for (int n = 17; n <= 20; n++) push(n, 0, 1, 1'b0);
    for (int n = 21; n <= 23; n++) push(n, 0, 2, 1'b0);
    fire_start();
    for (int n = 0; n <= 23; n++) begin
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if ({count, state, done, running} !== {e.cnt, e.st, e.dn, e.st == 2'd1}) begin
          bad++;
          $display("FAIL clear_prio n=%0d got count=%0d state=%0d done=%b want count=%0d state=%0d done=%b",
                   n, count, state, done, e.cnt, e.st, e.dn);
        end
      end
      clear = (n == 12);
      start = (n == 12) || (n == 16) || (n == 20);
      pause = (n == 20);
      step();
    end
    clear = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic test_sync_reset();
    go_idle();
    limit = 10'd9;
    for (int n = 0; n <= 28; n++) push(n, n / 4, 1, 1'b0);
    for (int n = 29; n <= 31; n++) push(n, 0, 0, 1'b0);
    fire_start();
    for (int n = 0; n <= 31; n++) begin
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if ({count, state, done, running} !== {e.cnt, e.st, e.dn, e.st == 2'd1}) begin
          bad++;
          $display("FAIL sync_reset n=%0d got count=%0d state=%0d running=%b want count=%0d state=%0d",
                   n, count, state, running, e.cnt, e.st);
        end
      end
      reset = (n == 28);
      start = (n == 28);
      step();
    end
    reset = 1'b0; start = 1'b0;
  endtask

  // TICK_DIV=1 instance: limit 1023 clamps to 999, then a zero limit.
  task automatic test_clamp_zero_limit();
    limit1 = 10'd1023;
    push(0, 0, 1, 1'b0);
    push(1, 1, 1, 1'b0);
    push(500, 500, 1, 1'b0);
    push(999, 999, 1, 1'b0);
    push(1000, 999, 3, 1'b1);
    push(1001, 999, 3, 1'b0);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int n = 0; n <= 1001; n++) begin
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if ({count1, state1, done1, running1} !== {e.cnt, e.st, e.dn, e.st == 2'd1}) begin
          bad++;
          $display("FAIL clamp n=%0d got count=%0d state=%0d done=%b want count=%0d state=%0d done=%b",
                   n, count1, state1, done1, e.cnt, e.st, e.dn);
        end
      end
      step();
    end
    limit1 = 10'd0;
    push(0, 0, 1, 1'b0);
    push(1, 0, 3, 1'b1);
    push(2, 0, 3, 1'b0);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int n = 0; n <= 2; n++) begin
      while (sb.size() > 0 && sb[0].cyc == n) begin
        e = sb.pop_front();
        total++;
        if ({count1, state1, done1, running1} !== {e.cnt, e.st, e.dn, e.st == 2'd1}) begin
          bad++;
          $display("FAIL zero_limit n=%0d got count=%0d state=%0d done=%b want count=%0d state=%0d done=%b",
                   n, count1, state1, done1, e.cnt, e.st, e.dn);
        end
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; wrap_en = 1'b0;
    limit = 10'd0; start1 = 1'b0; clear1 = 1'b0; limit1 = 10'd0;
    step();
    step();
    test_reset();
    test_stop_at_limit();
    test_restart_from_done();
    test_wrap();
    test_pause_resume();
    test_clear_priority();
    test_sync_reset();
    test_clamp_zero_limit();
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
